uart_tx_fifo: RTL and testbench

- Serial transmit stage directly downstream of the terminal text buffer.
- Accepts the single-cycle byte pulses the buffer emits on its o_serial/o_serial_v outputs.
- Queues those bytes in a small FIFO and shifts them out on a UART TX line as 8N1 frames, LSB first, toward the host terminal.
- The upstream buffer has no backpressure, so this block absorbs bursts and flags any byte it loses.

---
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small FIFO that absorbs unthrottled byte pulses
// from the text buffer; bytes arriving while full are dropped and flagged.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_data_v,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_overflow
);

  localparam int unsigned      DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  state_e             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               ovf_q, ovf_d;
  logic               push, pop, baud_done;

  // A full FIFO drops the byte even when the transmitter pops on the same edge.
  assign push      = i_data_v && (count_q != DEPTH_C);
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames are contiguous.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    count_d  = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    ovf_d    = ovf_q | (i_data_v && (count_q == DEPTH_C));
    busy_d   = (state_q != S_IDLE) || (count_q != '0);
    // The line follows the current state one cycle later, giving each bit a full cell.
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations share one stimulus stream and
// each is compared every cycle against a frame-schedule reference model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       data_v;
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int C     = (gi == 2) ? 104 : 4;
    localparam int AW    = (gi == 0) ? 2 : 4;
    localparam int DEPTH = 1 << AW;

    logic       tx, busy, empty, full, ovf;
    logic [4:0] exp_o;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_data     (data),
      .i_data_v   (data_v),
      .o_tx       (tx),
      .o_busy     (busy),
      .o_empty    (empty),
      .o_full     (full),
      .o_overflow (ovf)
    );

    // Reference: a queue of accepted bytes plus the edge of the most recent pop.
    // A frame popped at edge p drives the line on edges p+1 .. p+10*C.
    initial begin
      byte unsigned pend[$];
      int         t;
      int         lp;
      bit         lp_valid;
      logic [7:0] lp_data;
      int         prev;
      int         j;
      bit         active;
      bit         m_tx, m_busy, m_ovf;
      t = 0; lp = 0; lp_valid = 0; lp_data = '0;
      m_tx = 1; m_busy = 0; m_ovf = 0;
      forever begin
        @(posedge clk);
        if (!rst) begin
          pend.delete();
          lp_valid = 0;
          m_tx = 1; m_busy = 0; m_ovf = 0;
        end else begin
          prev   = pend.size();
          active = lp_valid && (t - 1 < lp + 10 * C);
          m_busy = active || (prev > 0);
          m_tx   = 1'b1;
          if (lp_valid && t <= lp + 10 * C) begin
            j = (t - lp - 1) / C;
            m_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : lp_data[j - 1];
          end
          if (prev > 0 && (!lp_valid || t >= lp + 10 * C)) begin
            lp = t;
            lp_valid = 1;
            lp_data = pend.pop_front();
          end
          if (data_v) begin
            if (prev < DEPTH) pend.push_back(data);
            else m_ovf = 1;
          end
        end
        exp_o = {m_tx, m_busy, pend.size() == 0, pend.size() == DEPTH, m_ovf};
        t++;
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (chk_en)
          check($sformatf("cfg%0d {tx,busy,empty,full,ovf}", gi),
                {27'd0, tx, busy, empty, full, ovf}, {27'd0, exp_o});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] d);
    data   = d;
    data_v = 1'b1;
    @(negedge clk);
    data_v = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       exp_bit;
    int         rate;
    rst = 1'b0; data = '0; data_v = 1'b0;
    idle(3);
    chk_en = 1'b1;
    check("reset tx",    {31'd0, g_cfg[2].tx},    32'd1);
    check("reset busy",  {31'd0, g_cfg[2].busy},  32'd0);
    check("reset empty", {31'd0, g_cfg[2].empty}, 32'd1);
    check("reset full",  {31'd0, g_cfg[2].full},  32'd0);
    check("reset ovf",   {31'd0, g_cfg[2].ovf},   32'd0);
    rst = 1'b1;
    idle(2);

    // Single byte 0x41 at edge N: line falls at N+2, busy spans N+1..N+41.
    b = 8'h41;
    put(b);
    idle(1);
    check("0x41 busy@N+1", {31'd0, g_cfg[1].busy}, 32'd1);
    idle(1);
    for (int k = 0; k < 10; k++) begin
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k - 1];
      check($sformatf("0x41 cell%0d", k), {31'd0, g_cfg[1].tx}, {31'd0, exp_bit});
      if (k < 9) idle(4);
    end
    idle(3);
    check("0x41 busy@N+41", {31'd0, g_cfg[1].busy}, 32'd1);
    idle(1);
    check("0x41 busy@N+42",  {31'd0, g_cfg[1].busy},  32'd0);
    check("0x41 empty@N+42", {31'd0, g_cfg[1].empty}, 32'd1);

    // Back-to-back frames.
    put(8'h55);
    put(8'hAA);
    idle(100);

    // Six consecutive writes into the depth-4 instance: the sixth is dropped.
    for (int i = 1; i <= 5; i++) put(8'(i));
    check("burst6 full@w5", {31'd0, g_cfg[0].full}, 32'd1);
    check("burst6 ovf@w5",  {31'd0, g_cfg[0].ovf},  32'd0);
    put(8'd6);
    check("burst6 ovf@w6",  {31'd0, g_cfg[0].ovf},  32'd1);
    idle(240);

    // Overflow stays sticky across a fresh frame.
    put(8'h7E);
    idle(60);
    check("0x7E ovf sticky", {31'd0, g_cfg[0].ovf}, 32'd1);

    // Reset during DATA of a frame with three bytes still queued.
    for (int i = 0; i < 4; i++) put(8'h31 + 8'(i));
    idle(12);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("midrst cfg%0d tx", c),
            {31'd0, (c == 0) ? g_cfg[0].tx : (c == 1) ? g_cfg[1].tx : g_cfg[2].tx}, 32'd1);
      check($sformatf("midrst cfg%0d busy", c),
            {31'd0, (c == 0) ? g_cfg[0].busy : (c == 1) ? g_cfg[1].busy : g_cfg[2].busy}, 32'd0);
      check($sformatf("midrst cfg%0d empty", c),
            {31'd0, (c == 0) ? g_cfg[0].empty : (c == 1) ? g_cfg[1].empty : g_cfg[2].empty}, 32'd1);
      check($sformatf("midrst cfg%0d ovf", c),
            {31'd0, (c == 0) ? g_cfg[0].ovf : (c == 1) ? g_cfg[1].ovf : g_cfg[2].ovf}, 32'd0);
    end
    idle(60);

    // Seventeen consecutive bytes; drain the default-rate instance completely.
    for (int i = 0; i <= 16; i++) put(8'(i));
    check("burst17 ovf", {31'd0, g_cfg[2].ovf}, 32'd0);
    idle(18000);

    // Randomised traffic with alternating light/heavy load and rare resets.
    rate = 5;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 200 == 0) rate = (rate == 5) ? 60 : 5;
      rst    = ($urandom_range(0, 799) != 0);
      data   = 8'($urandom);
      data_v = ($urandom_range(0, 99) < rate);
      @(negedge clk);
    end
    rst = 1'b1;
    data_v = 1'b0;
    idle(18000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
